link_capture_array: RTL
=======================

LINK_CAPTURE_ARRAY -- requirements
Module: link_capture_array

Interface
REQ-001 SHALL have parameter ENC, default "TP"; link encoding: "TP" (two-phase dual-rail) or "FP" (four-phase dual-rail, return-to-zero).
REQ-002 SHALL have parameter WIDTH, default 8; data bits per channel.
REQ-003 SHALL have parameter CHANNELS, default 4; number of independent input links.
REQ-004 SHALL have parameter DEPTH, default 8; capture FIFO entries, power of 2, minimum 2.
REQ-005 SHALL have parameter SYNC_STAGES, default 2; flip-flop synchronizer depth on every input rail, minimum 2.
REQ-006 SHALL have parameter ACK_DELAY, default 3; clock cycles between capture and ack_o change, range 0..255.
REQ-007 SHALL have port clk, input, 1 bit; single clock for all state.
REQ-008 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-009 SHALL have port in, input, [CHANNELS][WIDTH][2]; dual-rail links, rail 1 = logic one, rail 0 = logic zero.
REQ-010 SHALL have port ack_o, output, [CHANNELS]; per-channel acknowledge.
REQ-011 SHALL have port data_o, output, [WIDTH]; decoded word at FIFO head.
REQ-012 SHALL have port chan_o, output, max(1,$clog2(CHANNELS)); source channel of head word.
REQ-013 SHALL have port valid_o, output, 1; FIFO non-empty.
REQ-014 SHALL have port ready_i, input, 1; consumer accepts head word when valid_o && ready_i at posedge clk.
REQ-015 SHALL have port err_o, output, [CHANNELS]; sticky per-channel encoding error.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH+1); FIFO occupancy.

Function
REQ-017 SHALL decode all rails from the final synchronizer stage only; raw in is never used combinationally.
REQ-018 SHALL run one FSM per channel: IDLE -> CAPT -> DELAY -> RELEASE -> IDLE.
REQ-019 IDLE, TP: word complete when every bit has exactly one rail differing from stored reference state; bit value = rail-1 differs.
REQ-020 IDLE, FP: word complete when every bit has exactly one rail high; bit value = rail 1.
REQ-021 Partial words (some bits not complete) SHALL hold the channel in IDLE with no side effect.
REQ-022 Both rails changed (TP) or both rails high (FP) on any bit SHALL set err_o[ch], stay set until reset, and the word SHALL not be captured; channel stays IDLE.
REQ-023 CAPT: channel requests a FIFO write; one write per cycle, round-robin arbitration starting at pointer, pointer moves to granted channel + 1 mod CHANNELS.
REQ-024 Grant SHALL occur only when FIFO not full; full blocks all grants even if a pop occurs the same cycle.
REQ-025 On grant, {decoded word, channel index} SHALL be written and, in TP, reference state updated to current synchronized rails; channel moves to DELAY.
REQ-026 DELAY: counts ACK_DELAY cycles (0 = zero cycles), then in TP toggles ack_o[ch], in FP sets ack_o[ch]=1; moves to RELEASE.
REQ-027 RELEASE, TP: returns to IDLE next cycle.
REQ-028 RELEASE, FP: waits for all 2*WIDTH rails low (spacer), then counts ACK_DELAY cycles, clears ack_o[ch], returns to IDLE.
REQ-029 ack_o SHALL be registered, glitch-free, and change at most once per token phase.
REQ-030 FIFO: push and pop in the same cycle when neither full nor empty SHALL leave count_o unchanged; pop when empty ignored.
REQ-031 Pointers SHALL wrap modulo DEPTH; count_o = DEPTH means full.
REQ-032 data_o/chan_o SHALL show the head entry combinationally from storage; undefined contents never shown while valid_o=1.
REQ-033 Capture-to-valid_o latency SHALL be one cycle after the grant edge (FIFO was empty).

Reset
REQ-034 rst=0 SHALL asynchronously clear: ack_o, err_o, valid_o, count_o, data_o, chan_o to 0; all FSMs IDLE; TP reference state all zero; FIFO pointers and arbiter pointer 0; synchronizers 0.
REQ-035 Reset mid-transfer SHALL discard FIFO contents and in-flight tokens; after release, TP channels treat current rails versus zero reference as new data.
REQ-036 Reset release SHALL be synchronized internally so no FSM leaves IDLE before SYNC_STAGES+1 cycles after rst rises.

Verification
REQ-037 FP, CHANNELS=1, WIDTH=8, ACK_DELAY=3: drive 0xA5 codeword, ready_i=1 -> valid_o with data_o=0xA5, chan_o=0; ack_o rises 3 cycles after grant; spacer -> ack_o falls 3 cycles later.
REQ-038 TP, WIDTH=8: tokens 0x3C then 0xC3 with ack handshake -> two FIFO words 0x3C, 0xC3; ack_o toggles 0->1->0.
REQ-039 CHANNELS=4, all complete same cycle, ready_i=1 -> entries in chan order 0,1,2,3; next simultaneous round starts from channel 0 again.
REQ-040 DEPTH=4, ready_i=0, 6 tokens on channel 0 -> count_o=4, ack_o withheld on token 5 until one pop, then capture.
REQ-041 FP bit 2 both rails high -> err_o[ch]=1, no FIFO write, no ack; persists until rst=0.
REQ-042 rst=0 asserted during DELAY with count_o=2 -> all outputs 0 immediately, count_o=0 after release.

Source files
------------

// File: rtl/link_capture_array.sv
// link_capture_array: captures words from several dual-rail asynchronous links
// (two-phase or four-phase return-to-zero), synchronizes every rail, decodes
// each channel with its own handshake FSM, and merges the words into a single
// FIFO through a round-robin arbiter. ack_o closes the handshake per channel.
module link_capture_array #(
    parameter string ENC         = "TP",
    parameter int    WIDTH       = 8,
    parameter int    CHANNELS    = 4,
    parameter int    DEPTH       = 8,
    parameter int    SYNC_STAGES = 2,
    parameter int    ACK_DELAY   = 3,
    localparam int   CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int   NW          = $clog2(DEPTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CHANNELS-1:0][WIDTH-1:0][1:0]   in,
    output logic [CHANNELS-1:0]                   ack_o,
    output logic [WIDTH-1:0]                      data_o,
    output logic [CW-1:0]                         chan_o,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [CHANNELS-1:0]                   err_o,
    output logic [NW-1:0]                         count_o
);

    localparam bit IS_FP = (ENC == "FP");
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPT, DELAY, RELEASE} state_t;

    // ------------------------------------------------------------------
    // Reset release and rail synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]                 run_sync_reg;
    logic                                   run_en;
    logic [CHANNELS-1:0][WIDTH-1:0][1:0]    sync_reg [SYNC_STAGES];
    logic [CHANNELS-1:0][WIDTH-1:0][1:0]    rails;

    // Hold every FSM in IDLE until reset release has passed through the chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync_reg <= '0;
        end else begin
            run_sync_reg <= {run_sync_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign run_en = run_sync_reg[SYNC_STAGES-1];

    // Multi-stage synchronizer on every rail; only the last stage is decoded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign rails = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Shared arbiter / FIFO signals
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0]                req;
    logic [CHANNELS-1:0]                grant_vec;
    logic [CHANNELS-1:0][WIDTH-1:0]     cap_word;
    logic [CW-1:0]                      grant_idx;
    logic                               grant_any;
    logic [CW-1:0]                      arb_ptr_reg, arb_ptr_next;
    int                                 scan_idx;

    logic [WIDTH+CW-1:0]                mem [DEPTH];
    logic [AW-1:0]                      wr_ptr_reg, rd_ptr_reg;
    logic [NW-1:0]                      count_reg, count_next;
    logic                               full, empty, push, pop;

    assign full  = (count_reg == NW'(DEPTH));
    assign empty = (count_reg == '0);

    // ------------------------------------------------------------------
    // Per-channel decode and handshake FSM
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        state_t                     state_reg, state_next;
        logic [WIDTH-1:0][1:0]      ref_reg, ref_next;
        logic [WIDTH-1:0]           word_reg, word_next;
        logic [7:0]                 cnt_reg, cnt_next;
        logic                       ack_reg, ack_next;
        logic                       err_reg, err_next;
        logic                       spacer_reg, spacer_next;
        logic [WIDTH-1:0][1:0]      diff;
        logic [WIDTH-1:0]           bit_done, bit_err, bit_val;
        logic                       all_low;

        // Two-phase tokens are transitions against the last accepted rails;
        // four-phase tokens are levels against the all-zero spacer.
        assign diff    = IS_FP ? rails[gi] : (rails[gi] ^ ref_reg);
        assign all_low = (rails[gi] == '0);

        for (genvar bi = 0; bi < WIDTH; bi++) begin : g_bit
            assign bit_done[bi] = diff[bi][1] ^ diff[bi][0];
            assign bit_err[bi]  = diff[bi][1] & diff[bi][0];
            assign bit_val[bi]  = diff[bi][1];
        end

        // Next-state logic: detect word, request FIFO slot, pace the ack
        always_comb begin
            state_next  = state_reg;
            ref_next    = ref_reg;
            word_next   = word_reg;
            cnt_next    = cnt_reg;
            ack_next    = ack_reg;
            err_next    = err_reg;
            spacer_next = spacer_reg;
            case (state_reg)
                IDLE: begin
                    if (run_en) begin
                        if (|bit_err) begin
                            err_next = 1'b1;
                        end else if (&bit_done) begin
                            word_next  = bit_val;
                            state_next = CAPT;
                        end
                    end
                end
                CAPT: begin
                    if (grant_vec[gi]) begin
                        if (!IS_FP) begin
                            ref_next = rails[gi];
                        end
                        spacer_next = 1'b0;
                        if (ACK_DELAY == 0) begin
                            ack_next   = IS_FP ? 1'b1 : ~ack_reg;
                            state_next = RELEASE;
                        end else begin
                            cnt_next   = 8'(ACK_DELAY);
                            state_next = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_reg <= 8'd1) begin
                        ack_next   = IS_FP ? 1'b1 : ~ack_reg;
                        state_next = RELEASE;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
                RELEASE: begin
                    if (!IS_FP) begin
                        state_next = IDLE;
                    end else if (!spacer_reg) begin
                        if (all_low) begin
                            if (ACK_DELAY == 0) begin
                                ack_next   = 1'b0;
                                state_next = IDLE;
                            end else begin
                                spacer_next = 1'b1;
                                cnt_next    = 8'(ACK_DELAY);
                            end
                        end
                    end else if (cnt_reg <= 8'd1) begin
                        ack_next    = 1'b0;
                        spacer_next = 1'b0;
                        state_next  = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Channel state registers; ack comes straight from a flop
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_reg  <= IDLE;
                ref_reg    <= '0;
                word_reg   <= '0;
                cnt_reg    <= '0;
                ack_reg    <= 1'b0;
                err_reg    <= 1'b0;
                spacer_reg <= 1'b0;
            end else begin
                state_reg  <= state_next;
                ref_reg    <= ref_next;
                word_reg   <= word_next;
                cnt_reg    <= cnt_next;
                ack_reg    <= ack_next;
                err_reg    <= err_next;
                spacer_reg <= spacer_next;
            end
        end

        assign req[gi]      = (state_reg == CAPT);
        assign cap_word[gi] = word_reg;
        assign ack_o[gi]    = ack_reg;
        assign err_o[gi]    = err_reg;
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------

    // Scan requests starting at the pointer; full FIFO suppresses every grant
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            scan_idx = (int'(arb_ptr_reg) + i) % CHANNELS;
            if (!grant_any && !full && req[CW'(scan_idx)]) begin
                grant_any               = 1'b1;
                grant_idx               = CW'(scan_idx);
                grant_vec[CW'(scan_idx)] = 1'b1;
            end
        end
        arb_ptr_next = arb_ptr_reg;
        if (grant_any) begin
            arb_ptr_next = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Arbiter pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_ptr_reg <= '0;
        end else begin
            arb_ptr_reg <= arb_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO
    // ------------------------------------------------------------------
    assign push = grant_any;
    assign pop  = !empty && ready_i;

    // Occupancy: simultaneous push and pop cancel out
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage array; contents are never shown unless valid_o is set
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {grant_idx, cap_word[grant_idx]};
        end
    end

    // FIFO pointers and count; DEPTH is a power of two so pointers wrap freely
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign valid_o           = !empty;
    assign count_o           = count_reg;
    assign {chan_o, data_o}  = valid_o ? mem[rd_ptr_reg] : '0;

endmodule
